// File: rtl/sd_fifo_wr_arb.sv
// Burst-locking round-robin arbiter sharing one srdy/drdy FIFO write port.
// Data path is combinational; only the arbitration state is registered.
module sd_fifo_wr_arb #(
    parameter int inputs = 4,
    parameter int width  = 8,
    parameter int burst  = 4,
    localparam int isz   = $clog2(inputs),
    localparam int bsz   = $clog2(burst + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [inputs-1:0]         p_srdy,
    output logic [inputs-1:0]         p_drdy,
    input  logic [inputs*width-1:0]   p_data,
    output logic                      f_srdy,
    input  logic                      f_drdy,
    output logic [width-1:0]          f_data,
    output logic [isz-1:0]            f_src
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q, state_d;
    logic [isz-1:0] rr_ptr_q, rr_ptr_d;
    logic [isz-1:0] owner_q, owner_d;
    logic [bsz-1:0] cnt_q, cnt_d;

    logic [isz-1:0] start, idx, winner;
    logic           owner_hold, found, xfer;
    logic [width-1:0] pd [inputs];

    // Explicit wrap so non-power-of-2 producer counts never index past inputs-1.
    function automatic logic [isz-1:0] inc(input logic [isz-1:0] v);
        return (v == isz'(inputs - 1)) ? '0 : v + 1'b1;
    endfunction

    for (genvar i = 0; i < inputs; i++) begin : g_lane
        assign pd[i]     = p_data[i*width +: width];
        assign p_drdy[i] = f_drdy & f_srdy & (winner == isz'(i));
    end

    assign f_srdy = |p_srdy;
    assign f_data = pd[winner];
    assign f_src  = winner;
    assign xfer   = f_srdy & f_drdy;

    always_comb begin
        owner_hold = (state_q == LOCKED) && p_srdy[owner_q];
        start      = (state_q == LOCKED) ? inc(owner_q) : rr_ptr_q;
        winner     = start;
        found      = 1'b0;
        idx        = start;
        for (int k = 0; k < inputs; k++) begin
            if (!found && p_srdy[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = inc(idx);
        end
        if (owner_hold) winner = owner_q;
    end

    // A full FIFO freezes all arbitration state.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        if (f_drdy) begin
            if (owner_hold) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == bsz'(burst)) begin
                    rr_ptr_d = inc(owner_q);
                    state_d  = IDLE;
                end
            end else if (xfer) begin
                owner_d = winner;
                cnt_d   = bsz'(1);
                if (burst == 1) begin
                    rr_ptr_d = inc(winner);
                    state_d  = IDLE;
                end else begin
                    state_d  = LOCKED;
                end
            end else if (state_q == LOCKED) begin
                rr_ptr_d = inc(owner_q);
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sd_fifo_wr_arb.sv
// Bench for sd_fifo_wr_arb: a 4-input/burst-4 instance and a 3-input/burst-1 instance,
// checked each cycle against a queue-free scan model plus directed literal expectations.
module tb_sd_fifo_wr_arb;

    typedef struct {
        int rr;
        int owner;
        int cnt;
        int locked;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  a_srdy, a_drdy;
    logic [31:0] a_data;
    logic        a_fsrdy, a_fdrdy;
    logic [7:0]  a_fdata;
    logic [1:0]  a_fsrc;

    logic [2:0]  b_srdy, b_drdy;
    logic [23:0] b_data;
    logic        b_fsrdy, b_fdrdy;
    logic [7:0]  b_fdata;
    logic [1:0]  b_fsrc;

    int errors = 0;
    int checks = 0;
    mst_t ma = '{default: 0};
    mst_t mb = '{default: 0};

    always #5 clk = ~clk;

    sd_fifo_wr_arb #(.inputs(4), .width(8), .burst(4)) dut_a (
        .clk(clk), .reset(rst_n), .p_srdy(a_srdy), .p_drdy(a_drdy), .p_data(a_data),
        .f_srdy(a_fsrdy), .f_drdy(a_fdrdy), .f_data(a_fdata), .f_src(a_fsrc));

    sd_fifo_wr_arb #(.inputs(3), .width(8), .burst(1)) dut_b (
        .clk(clk), .reset(rst_n), .p_srdy(b_srdy), .p_drdy(b_drdy), .p_data(b_data),
        .f_srdy(b_fsrdy), .f_drdy(b_fdrdy), .f_data(b_fdata), .f_src(b_fsrc));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int m_winner(mst_t s, logic [3:0] srdy, int n);
        int start;
        if (s.locked != 0 && srdy[s.owner]) return s.owner;
        start = (s.locked != 0) ? (s.owner + 1) % n : s.rr;
        for (int k = 0; k < n; k++)
            if (srdy[(start + k) % n]) return (start + k) % n;
        return -1;
    endfunction

    function automatic mst_t m_step(mst_t s, logic [3:0] srdy, logic fdrdy, int n, int b);
        mst_t r = s;
        int w;
        if (!fdrdy) return r;
        w = m_winner(s, srdy, n);
        if (w < 0) begin
            if (s.locked != 0) begin
                r.rr = (s.owner + 1) % n;
                r.locked = 0;
            end
        end else if (s.locked != 0 && srdy[s.owner]) begin
            r.cnt = s.cnt + 1;
            if (r.cnt == b) begin
                r.rr = (s.owner + 1) % n;
                r.locked = 0;
            end
        end else begin
            r.owner = w;
            r.cnt = 1;
            if (b == 1) begin
                r.rr = (w + 1) % n;
                r.locked = 0;
            end else begin
                r.locked = 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= m_step(ma, a_srdy, a_fdrdy, 4, 4);
            mb <= m_step(mb, {1'b0, b_srdy}, b_fdrdy, 3, 1);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int wa, wb;
        wa = m_winner(ma, a_srdy, 4);
        chk("a_f_srdy", 32'(a_fsrdy), 32'(|a_srdy));
        chk("a_p_drdy", 32'(a_drdy), (wa >= 0 && a_fdrdy) ? 32'(1 << wa) : 32'd0);
        if (wa >= 0) begin
            chk("a_f_src", 32'(a_fsrc), 32'(wa));
            chk("a_f_data", 32'(a_fdata), 32'(a_data[wa*8 +: 8]));
        end
        chk("a_rr_ptr", 32'(dut_a.rr_ptr_q), 32'(ma.rr));
        chk("a_owner", 32'(dut_a.owner_q), 32'(ma.owner));
        chk("a_cnt", 32'(dut_a.cnt_q), 32'(ma.cnt));
        chk("a_state", 32'(dut_a.state_q), 32'(ma.locked));
        wb = m_winner(mb, {1'b0, b_srdy}, 3);
        chk("b_f_srdy", 32'(b_fsrdy), 32'(|b_srdy));
        chk("b_p_drdy", 32'(b_drdy), (wb >= 0 && b_fdrdy) ? 32'(1 << wb) : 32'd0);
        if (wb >= 0) begin
            chk("b_f_src", 32'(b_fsrc), 32'(wb));
            chk("b_f_data", 32'(b_fdata), 32'(b_data[wb*8 +: 8]));
        end
        chk("b_rr_ptr", 32'(dut_b.rr_ptr_q), 32'(mb.rr));
        chk("b_state", 32'(dut_b.state_q), 32'(mb.locked));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp4 [3] = '{3, 3, 0};
        a_srdy = '0; a_data = '0; a_fdrdy = 1'b1;
        b_srdy = '0; b_data = 24'h222120; b_fdrdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rr", 32'(dut_a.rr_ptr_q), 0);
        chk("rst_state", 32'(dut_a.state_q), 0);
        chk("rst_f_srdy", 32'(a_fsrdy), 0);
        tick();
        rst_n = 1'b1;

        // Single source, burst boundary every 4 words.
        for (int i = 0; i < 8; i++) begin
            a_srdy = 4'b0100;
            a_data = {8'h00, 8'(8'h10 + i), 8'h00, 8'h00};
            @(negedge clk);
            chk("t1_src", 32'(a_fsrc), 2);
            chk("t1_data", 32'(a_fdata), 32'(8'h10 + i));
            chk("t1_drdy", 32'(a_drdy), 32'b0100);
            tick();
            chk("t1_state", 32'(dut_a.state_q), ((i + 1) % 4 != 0) ? 1 : 0);
        end
        a_srdy = '0;
        pulse_reset();

        // Full contention.
        a_data = 32'hD3D2D1D0;
        a_srdy = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_src", 32'(a_fsrc), 32'((i / 4) % 4));
            chk("t2_xfer", 32'(a_fsrdy & a_fdrdy), 1);
            tick();
            if (i % 4 == 3) chk("t2_rr", 32'(dut_a.rr_ptr_q), 32'((i / 4 + 1) % 4));
        end
        a_srdy = '0;
        pulse_reset();

        // Early release: owner 1 drops after 2 words, scan resumes at 2.
        a_srdy = 4'b0010;
        tick();
        tick();
        a_srdy = 4'b1001;
        @(negedge clk);
        chk("t3_src", 32'(a_fsrc), 3);
        chk("t3_drdy", 32'(a_drdy), 32'b1000);
        tick();
        chk("t3_cnt", 32'(dut_a.cnt_q), 1);
        chk("t3_owner", 32'(dut_a.owner_q), 3);

        // Backpressure mid-burst at cnt=2.
        tick();
        chk("t4_cnt0", 32'(dut_a.cnt_q), 2);
        a_fdrdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_drdy", 32'(a_drdy), 0);
            tick();
            chk("t4_cnt", 32'(dut_a.cnt_q), 2);
            chk("t4_owner", 32'(dut_a.owner_q), 3);
        end
        a_fdrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_src", 32'(a_fsrc), 32'(exp4[i]));
            tick();
            if (i == 1) begin
                chk("t4_cnt_end", 32'(dut_a.cnt_q), 4);
                chk("t4_state_end", 32'(dut_a.state_q), 0);
                chk("t4_rr_end", 32'(dut_a.rr_ptr_q), 0);
            end
        end
        a_srdy = '0;
        pulse_reset();

        // Reset mid-burst with owner=3, cnt=3.
        a_srdy = 4'b1000;
        repeat (3) tick();
        chk("t5_owner", 32'(dut_a.owner_q), 3);
        chk("t5_cnt", 32'(dut_a.cnt_q), 3);
        a_srdy = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_drdy", 32'(a_drdy), 32'b0001);
        chk("t5_rst_cnt", 32'(dut_a.cnt_q), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_first", 32'(a_fsrc), 0);
        tick();
        a_srdy = '0;

        // Three producers, burst of one.
        b_srdy = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_src", 32'(b_fsrc), 32'(i % 3));
            tick();
            chk("t6_rr_lt3", 32'(dut_b.rr_ptr_q < 2'd3), 1);
        end
        b_srdy = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
